alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides; the successor to the combinational 4-op ALU.
- Operand width is configurable, the opcode set is extended to 8 operations, status flags are added, and a user tag travels with each operation.
- Sits between an operation issuer (sequencer/testbench driver) and a result consumer that may stall.

Parameters:
- WIDTH, 8, operand width in bits (≥2, power of two); result is 2*WIDTH.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  alu_op_e (3)  operation select.
- in_tag  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- out_result  output  2*WIDTH  result.
- out_zero  output  1  out_result == 0.
- out_carry  output  1  carry/borrow/high-half flag (see below).
- out_ovf  output  1  signed overflow (ADD/SUB only, else 0).
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0; out_valid=0, out_result=0, all flags=0, out_tag=0; in_ready=1 once rst deasserts.
- Transfer occurs on in_valid&in_ready (input) and on out_valid&out_ready (output).
- Stage 1 registers a, b, op, tag. Stage 2 computes and registers result, flags and tag. out_* is driven directly from stage 2 registers.
- Latency: accept in cycle N produces out_valid in cycle N+2 when there is no backpressure. Throughput is 1 op/cycle.
- Advance rules:
  - s2_load = s1_valid & (~s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~s1_valid | s2_load.
  - A full pipe with out_ready=0 holds both stages; at most 2 ops are in flight.
- While out_valid=1 and out_ready=0, out_result/flags/tag must hold stable.
- Simultaneous accept and drain in the same cycle is legal; no bubble is inserted.
- Operations (a, b unsigned unless noted). Unused upper bits of the result are 0.
  - ADD: result[WIDTH:0] = a+b; carry = result[WIDTH]; ovf = signed overflow of a+b in WIDTH bits.
  - SUB: result[WIDTH:0] = {0,a}-{0,b}; carry = borrow = result[WIDTH]; ovf = signed overflow of a-b.
  - MUL: result = a*b (full 2*WIDTH); carry = |result[2W-1:W].
  - XOR / AND / OR: bitwise, WIDTH bits; carry = 0.
  - SHL: result = a << b[log2(WIDTH)-1:0], 2*WIDTH-wide (no bits lost); carry = |result[2W-1:W].
  - SHR: logical, a >> b[log2(WIDTH)-1:0]; carry = 0.
- zero flag is computed on the full 2*WIDTH result for every op.
- Reset asserted mid-operation discards all in-flight ops immediately; no partial result is ever presented.
- All 8 encodings are legal; there is no default/illegal path, though a defensive default yields result 0 and flags 0.

Decomposition:
- Shared package alu_pkg gains typedef enum bit [2:0] alu_op_e {ADD=0, SUB=1, MUL=2, XOR=3, AND=4, OR=5, SHL=6, SHR=7}. Encodings 0–3 match the existing opcode_e so legacy issuers map directly.
- The package also holds a function for signed-overflow detection.
- One sub-module, alu_pipe_core: purely combinational, computes result and flags from (a, b, op) and is instantiated between stage 1 and stage 2. The pipe/handshake logic lives in alu_pipe.

Test Plan (WIDTH=8):
- ADD a=200, b=100, tag=3 → two cycles later out_result=0x012C, carry=1, ovf=0, zero=0, out_tag=3.
- SUB a=5, b=7 → out_result=0x01FE, carry=1; separately ADD 0x7F+0x01 → 0x0080, ovf=1, carry=0.
- MUL 255*255 → 0xFE01, carry=1; SHL a=0x81, b=4 → 0x0810, carry=1; XOR 0x5A^0x5A → 0x0000, zero=1.
- Backpressure: out_ready=0, issue 3 back-to-back ops → in_ready=0 after 2 accepts, outputs stable; raise out_ready → results emerge in order with correct tags, third op then accepted.
- Streaming: out_ready=1, 16 random ops on consecutive cycles → 16 results on 16 consecutive cycles matching a reference model.
- Reset mid-operation: assert rst asynchronously with 2 ops in flight → out_valid=0 and outputs 0 immediately, nothing emitted after release, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 8-entry opcode set and the signed-overflow helper.
// Encodings 0-3 keep the legacy opcode values so older issuers map directly.
package alu_pkg;

  typedef enum bit [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    XOR = 3'd3,
    AND = 3'd4,
    OR  = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  // Signed overflow from the sign bits of both operands and of the WIDTH-bit result.
  function automatic logic add_sub_ovf(input logic sign_a, input logic sign_b,
                                       input logic sign_r, input logic is_sub);
    if (is_sub)
      return (sign_a ^ sign_b) & (sign_r ^ sign_a);
    else
      return ~(sign_a ^ sign_b) & (sign_r ^ sign_a);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and status flags from (a, b, op).
// Sits between the operand stage and the result stage of alu_pipe.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  alu_op_e            op,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               ovf
);

  localparam int SH_W = $clog2(WIDTH);

  typedef logic [2*WIDTH-1:0] res_t;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  res_t           prod;
  res_t           shl_res;
  res_t           shr_res;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign prod    = res_t'(a) * res_t'(b);
  assign shl_res = res_t'(a) << b[SH_W-1:0];
  assign shr_res = res_t'(a >> b[SH_W-1:0]);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ADD: begin
        result = res_t'(sum);
        carry  = sum[WIDTH];
        ovf    = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      SUB: begin
        result = res_t'(diff);
        carry  = diff[WIDTH];
        ovf    = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      MUL: begin
        result = prod;
        carry  = |prod[2*WIDTH-1:WIDTH];
      end
      XOR: result = res_t'(a ^ b);
      AND: result = res_t'(a & b);
      OR:  result = res_t'(a | b);
      SHL: begin
        result = shl_res;
        carry  = |shl_res[2*WIDTH-1:WIDTH];
      end
      SHR: result = shr_res;
      default: begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: stage 1 holds the
// operands, stage 2 holds the computed result, flags and tag that drive out_*.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  alu_op_e            in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  alu_op_e            s1_op;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_valid;
  logic [2*WIDTH-1:0] s2_result;
  logic               s2_zero;
  logic               s2_carry;
  logic               s2_ovf;
  logic [TAG_W-1:0]   s2_tag;

  logic [2*WIDTH-1:0] c_result;
  logic               c_zero;
  logic               c_carry;
  logic               c_ovf;

  logic s1_load;
  logic s2_load;

  // Stage 2 refills whenever it is empty or its result leaves this cycle,
  // so accept and drain can overlap without a bubble.
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (c_result),
    .zero   (c_zero),
    .carry  (c_carry),
    .ovf    (c_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ADD;
      s1_tag   <= '0;
    end else begin
      if (s1_load) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_tag <= in_tag;
      end
      if (s1_load)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;
    end
  end

  // Result registers are reset too: the outputs must read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_carry  <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (s2_load) begin
        s2_result <= c_result;
        s2_zero   <= c_zero;
        s2_carry  <= c_carry;
        s2_ovf    <= c_ovf;
        s2_tag    <= s1_tag;
      end
      if (s2_load)
        s2_valid <= 1'b1;
      else if (out_ready)
        s2_valid <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_carry  = s2_carry;
  assign out_ovf    = s2_ovf;
  assign out_tag    = s2_tag;

endmodule
